// File: rtl/krv_test_monitor_pkg.sv
// Shared types for the krv test-end monitor: FSM state encodings and index-width helper.
// The optional PC trace buffer is enabled by defining KRV_TEST_MON_TRACE_EN.
package krv_test_monitor_pkg;

  typedef enum logic [2:0] {
    MON_IDLE    = 3'd0,
    MON_RUN     = 3'd1,
    MON_CHECK   = 3'd2,
    MON_PASS    = 3'd3,
    MON_FAIL    = 3'd4,
    MON_TIMEOUT = 3'd5
  } mon_state_e;

  // Index width that stays at least one bit wide for single-entry tables.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/krv_test_monitor_if.sv
// Signal bundle between the core-side harness (master) and the test-end monitor (slave).
// Trace read signals exist only when KRV_TEST_MON_TRACE_EN is defined.
interface krv_test_monitor_if
  import krv_test_monitor_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_END = 4,
  parameter int TO_W    = 24
`ifdef KRV_TEST_MON_TRACE_EN
  , parameter int TRACE_D = 8
`endif
);

  localparam int IDX_W = idx_w(NUM_END);

  logic                    mon_en;
  logic [PC_W-1:0]         dec_pc;
  logic                    dec_pc_vld;
  logic [NUM_END*PC_W-1:0] end_pc;
  logic [NUM_END-1:0]      end_pc_en;
  logic [TO_W-1:0]         timeout_limit;
  logic [DATA_W-1:0]       sig_value;
  logic [DATA_W-1:0]       sig_expect;

  logic                    done;
  logic                    pass;
  logic                    fail;
  logic                    timeout;
  logic [IDX_W-1:0]        end_idx;
  logic [TO_W-1:0]         cycle_cnt;
  logic [PC_W-1:0]         stop_pc;

`ifdef KRV_TEST_MON_TRACE_EN
  logic [idx_w(TRACE_D)-1:0] trace_rd_idx;
  logic [PC_W-1:0]           trace_rd_pc;
`endif

  modport master (
    output mon_en, dec_pc, dec_pc_vld, end_pc, end_pc_en, timeout_limit, sig_value, sig_expect,
`ifdef KRV_TEST_MON_TRACE_EN
    output trace_rd_idx,
    input  trace_rd_pc,
`endif
    input  done, pass, fail, timeout, end_idx, cycle_cnt, stop_pc
  );

  modport slave (
    input  mon_en, dec_pc, dec_pc_vld, end_pc, end_pc_en, timeout_limit, sig_value, sig_expect,
`ifdef KRV_TEST_MON_TRACE_EN
    input  trace_rd_idx,
    output trace_rd_pc,
`endif
    output done, pass, fail, timeout, end_idx, cycle_cnt, stop_pc
  );

endinterface

// File: rtl/krv_test_monitor_trace_buf.sv
// Circular buffer of the most recent valid decode PCs; read index 0 is the newest entry.
// Instantiated by krv_test_monitor only when KRV_TEST_MON_TRACE_EN is defined.
module krv_pc_trace_buf
  import krv_test_monitor_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 8
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rstn,
  input  logic                      wr_en,
  input  logic [PC_W-1:0]           wr_pc,
  input  logic [idx_w(DEPTH)-1:0]   rd_idx,
  output logic [PC_W-1:0]           rd_pc
);

  localparam int AW = idx_w(DEPTH);

  logic [PC_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_addr;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign rd_addr = wr_ptr_reg - AW'(1) - rd_idx;
  assign rd_pc   = mem_reg[rd_addr];

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wr_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + AW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wr_pc;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/krv_test_monitor.sv
// Test-end monitor: end-PC comparator bank, cycle-budget timeout and sticky signature verdict.
// Define KRV_TEST_MON_TRACE_EN to add the PC trace buffer and its read port.
module krv_test_monitor
  import krv_test_monitor_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_END = 4,
  parameter int TO_W    = 24
`ifdef KRV_TEST_MON_TRACE_EN
  , parameter int TRACE_D = 8
`endif
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  krv_test_monitor_if.slave mon
);

  localparam int              IDX_W   = idx_w(NUM_END);
  localparam logic [TO_W-1:0] CNT_MAX = '1;

  mon_state_e          state_reg, state_next;
  logic [NUM_END-1:0]  hit;
  logic                hit_any;
  logic                hit_prev_reg;
  logic                detect;
  logic                expire;
  logic [IDX_W-1:0]    hit_idx;
  logic [IDX_W-1:0]    end_idx_reg;
  logic [PC_W-1:0]     stop_pc_reg;
  logic [TO_W-1:0]     cycle_cnt_reg;

  generate
    for (genvar gi = 0; gi < NUM_END; gi++) begin : g_cmp
      assign hit[gi] = mon.dec_pc_vld & mon.end_pc_en[gi] &
                       (mon.dec_pc == mon.end_pc[gi*PC_W +: PC_W]);
    end
  endgenerate

  assign hit_any = |hit;

  // Scan downwards so the lowest matching channel is the one left standing.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_END - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

  // Only a fresh hit counts, so a PC parked on the end address fires once.
  assign detect = (state_reg == MON_RUN) & hit_any & ~hit_prev_reg;
  assign expire = (state_reg == MON_RUN) & (mon.timeout_limit != '0) &
                  (cycle_cnt_reg == mon.timeout_limit - TO_W'(1));

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_reg     <= MON_IDLE;
      hit_prev_reg  <= 1'b0;
      cycle_cnt_reg <= '0;
      end_idx_reg   <= '0;
      stop_pc_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      hit_prev_reg <= (state_reg == MON_RUN) & hit_any;
      if (!mon.mon_en) begin
        cycle_cnt_reg <= '0;
        end_idx_reg   <= '0;
        stop_pc_reg   <= '0;
      end else begin
        // Counting stops on the cycle RUN is left, which freezes the value at the event.
        if ((state_reg == MON_RUN) && (state_next == MON_RUN) && (cycle_cnt_reg != CNT_MAX)) begin
          cycle_cnt_reg <= cycle_cnt_reg + TO_W'(1);
        end
        if (detect) begin
          end_idx_reg <= hit_idx;
          stop_pc_reg <= mon.dec_pc;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!mon.mon_en) begin
      state_next = MON_IDLE;
    end else begin
      case (state_reg)
        MON_IDLE:  state_next = MON_RUN;
        MON_RUN: begin
          if (detect)      state_next = MON_CHECK;
          else if (expire) state_next = MON_TIMEOUT;
        end
        MON_CHECK: state_next = (mon.sig_value == mon.sig_expect) ? MON_PASS : MON_FAIL;
        default:   state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    mon.done    = 1'b0;
    mon.pass    = 1'b0;
    mon.fail    = 1'b0;
    mon.timeout = 1'b0;
    case (state_reg)
      MON_PASS:    begin mon.done = 1'b1; mon.pass    = 1'b1; end
      MON_FAIL:    begin mon.done = 1'b1; mon.fail    = 1'b1; end
      MON_TIMEOUT: begin mon.done = 1'b1; mon.timeout = 1'b1; end
      default:     ;
    endcase
  end

  assign mon.end_idx   = end_idx_reg;
  assign mon.stop_pc   = stop_pc_reg;
  assign mon.cycle_cnt = cycle_cnt_reg;

`ifdef KRV_TEST_MON_TRACE_EN
  krv_pc_trace_buf #(
    .PC_W  (PC_W),
    .DEPTH (TRACE_D)
  ) u_trace_buf (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .wr_en    (mon.dec_pc_vld & ((state_reg == MON_RUN) | (state_reg == MON_CHECK))),
    .wr_pc    (mon.dec_pc),
    .rd_idx   (mon.trace_rd_idx),
    .rd_pc    (mon.trace_rd_pc)
  );
`endif

endmodule
